// File: rtl/q_cycle_if.sv
// Sequencer-to-core bundle: instruction/flag inputs to the sequencer and its per-phase enables.
// master = sequencer side, slave = core datapath side.
interface q_cycle_if;
    logic [13:0] instr_current;
    logic        skip_cond;
    logic        pcl_wr;
    logic        wake;
    logic [1:0]  q_phase;
    logic        instr_rd_en;
    logic        incr_pc_en;
    logic        pc_load_en;
    logic        pc_load_sel;
    logic        stack_push;
    logic        stack_pop;
    logic        regfile_rd_en;
    logic        alu_en;
    logic        regfile_wr_en;
    logic        w_wr_en;
    logic        status_wr_en;
    logic        nop_cycle;
    logic        sleeping;

    modport master (
        input  instr_current, skip_cond, pcl_wr, wake,
        output q_phase, instr_rd_en, incr_pc_en, pc_load_en, pc_load_sel,
               stack_push, stack_pop, regfile_rd_en, alu_en, regfile_wr_en,
               w_wr_en, status_wr_en, nop_cycle, sleeping
    );

    modport slave (
        output instr_current, skip_cond, pcl_wr, wake,
        input  q_phase, instr_rd_en, incr_pc_en, pc_load_en, pc_load_sel,
               stack_push, stack_pop, regfile_rd_en, alu_en, regfile_wr_en,
               w_wr_en, status_wr_en, nop_cycle, sleeping
    );
endinterface

// File: rtl/q_cycle_sequencer.sv
// Four-phase (Q1..Q4) instruction-cycle sequencer and decoder for the midrange core.
//   state   | meaning
//   Q1      | PC increment slot
//   Q2      | register-file operand read
//   Q3      | ALU evaluate, skip condition sampled on exit
//   Q4      | writeback, branch/stack strobes, next-instruction fetch
//   sleep_r | frozen at Q1 until wake
module q_cycle_sequencer #(
    parameter bit SLEEP_EN = 1'b1
) (
    input logic      clk,
    input logic      rst,
    q_cycle_if.master bus
);
    typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} q_t;

    q_t   q;
    logic flush, hold_pc, sleep_r, skip_r;

    logic [13:0] instr;
    logic [3:0]  op;
    logic        d, exec;
    logic        is_byte, is_bit, is_goto, is_call, is_ret_any, is_sleep, no_alu;
    logic        is_lit_alu, wr_f, wr_w, wr_st, skip_hit;
    logic        instr_rd, incr, pc_load, pc_sel, push, pop, rf_rd, alu, rf_wr, w_wr, st_wr;

    assign instr = bus.instr_current;
    assign op    = instr[11:8];
    assign d     = instr[7];
    assign exec  = !flush && !sleep_r;

    always_comb begin
        is_byte    = (instr[13:12] == 2'b00);
        is_bit     = (instr[13:12] == 2'b01);
        is_goto    = (instr[13:12] == 2'b10) && instr[11];
        is_call    = (instr[13:12] == 2'b10) && !instr[11];
        is_sleep   = (instr == 14'h0063);
        is_ret_any = (instr == 14'h0008) || (instr == 14'h0009)
                     || ((instr[13:12] == 2'b11) && (op[3:2] == 2'b01));
        is_lit_alu = (instr[13:12] == 2'b11) && op[3];
        no_alu     = is_goto || is_call || (instr == 14'h0008) || (instr == 14'h0009)
                     || is_sleep || (instr == 14'h0064);
        // MOVWF and CLRF are the d=1 encodings of opcodes 0000 and 0001
        wr_f       = (is_byte && d) || (is_bit && !instr[11]);
        wr_w       = (is_byte && !d && (op != 4'b0000))
                     || ((instr[13:12] == 2'b11) && !op[3]) || is_lit_alu;
        wr_st      = (is_byte && (op != 4'b0000) && (op != 4'b1011) && (op != 4'b1110)
                      && (op != 4'b1111)) || is_lit_alu;
        skip_hit   = (is_byte && ((op == 4'b1011) || (op == 4'b1111)) && bus.skip_cond)
                     || (is_bit && (op[3:2] == 2'b10) && !bus.skip_cond)
                     || (is_bit && (op[3:2] == 2'b11) && bus.skip_cond);
    end

    always_comb begin
        instr_rd = 1'b0;
        incr     = 1'b0;
        pc_load  = 1'b0;
        pc_sel   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        rf_rd    = 1'b0;
        alu      = 1'b0;
        rf_wr    = 1'b0;
        w_wr     = 1'b0;
        st_wr    = 1'b0;
        case (q)
            Q1: incr  = !sleep_r && !(flush && hold_pc);
            Q2: rf_rd = exec && (is_byte || is_bit);
            Q3: alu   = exec && !no_alu;
            Q4: begin
                instr_rd = !sleep_r;
                if (exec) begin
                    rf_wr   = wr_f;
                    w_wr    = wr_w;
                    st_wr   = wr_st;
                    pc_load = is_goto || is_call || is_ret_any;
                    pc_sel  = is_ret_any;
                    push    = is_call;
                    pop     = is_ret_any;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= Q1;
            flush   <= 1'b1;
            hold_pc <= 1'b1;
            sleep_r <= 1'b0;
            skip_r  <= 1'b0;
        end else if (sleep_r) begin
            if (bus.wake) sleep_r <= 1'b0;
        end else begin
            q <= q_t'(q + 2'd1);
            case (q)
                Q3: skip_r <= exec && skip_hit;
                Q4: begin
                    // a skip with a PCL write still counts as a load so the PC is held
                    flush   <= pc_load || (bus.pcl_wr && rf_wr) || skip_r;
                    hold_pc <= pc_load || (bus.pcl_wr && rf_wr);
                    skip_r  <= 1'b0;
                    if (SLEEP_EN && exec && is_sleep) sleep_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.q_phase       = q;
    assign bus.instr_rd_en   = instr_rd;
    assign bus.incr_pc_en    = incr;
    assign bus.pc_load_en    = pc_load;
    assign bus.pc_load_sel   = pc_sel;
    assign bus.stack_push    = push;
    assign bus.stack_pop     = pop;
    assign bus.regfile_rd_en = rf_rd;
    assign bus.alu_en        = alu;
    assign bus.regfile_wr_en = rf_wr;
    assign bus.w_wr_en       = w_wr;
    assign bus.status_wr_en  = st_wr;
    assign bus.nop_cycle     = flush && !rst;
    assign bus.sleeping      = sleep_r;
endmodule

// File: tb/tb_q_cycle_sequencer.sv
// Scoreboard bench for q_cycle_sequencer: an instruction-level mnemonic model queues the
// expected per-clock outputs, a negedge monitor pops and compares them.
module tb_q_cycle_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    q_cycle_if bus ();
    q_cycle_sequencer #(.SLEEP_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [1:0] q;
        logic instr_rd, incr, pc_load, pc_sel, push, pop, rf_rd, alu, rf_wr, w_wr, st_wr, nop, sleeping;
    } exp_t;

    typedef enum {
        M_NOP, M_RETURN, M_RETFIE, M_SLEEP, M_CLRWDT, M_MOVWF, M_CLRF, M_CLRW,
        M_SUBWF, M_DECF, M_IORWF, M_ANDWF, M_XORWF, M_ADDWF, M_MOVF, M_COMF, M_INCF,
        M_DECFSZ, M_RRF, M_RLF, M_SWAPF, M_INCFSZ, M_BCF, M_BSF, M_BTFSC, M_BTFSS,
        M_CALL, M_GOTO, M_MOVLW, M_RETLW, M_IORLW, M_ANDLW, M_XORLW, M_SUBLW, M_ADDLW, M_BAD
    } mn_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   m_flush, m_hold;

    function automatic mn_t mnemonic(input logic [13:0] i);
        casez (i)
            14'h0000:                 return M_NOP;
            14'h0008:                 return M_RETURN;
            14'h0009:                 return M_RETFIE;
            14'h0063:                 return M_SLEEP;
            14'h0064:                 return M_CLRWDT;
            14'b00_0000_1???_????:    return M_MOVWF;
            14'b00_0001_1???_????:    return M_CLRF;
            14'b00_0001_0???_????:    return M_CLRW;
            14'b00_0010_????_????:    return M_SUBWF;
            14'b00_0011_????_????:    return M_DECF;
            14'b00_0100_????_????:    return M_IORWF;
            14'b00_0101_????_????:    return M_ANDWF;
            14'b00_0110_????_????:    return M_XORWF;
            14'b00_0111_????_????:    return M_ADDWF;
            14'b00_1000_????_????:    return M_MOVF;
            14'b00_1001_????_????:    return M_COMF;
            14'b00_1010_????_????:    return M_INCF;
            14'b00_1011_????_????:    return M_DECFSZ;
            14'b00_1100_????_????:    return M_RRF;
            14'b00_1101_????_????:    return M_RLF;
            14'b00_1110_????_????:    return M_SWAPF;
            14'b00_1111_????_????:    return M_INCFSZ;
            14'b01_00??_????_????:    return M_BCF;
            14'b01_01??_????_????:    return M_BSF;
            14'b01_10??_????_????:    return M_BTFSC;
            14'b01_11??_????_????:    return M_BTFSS;
            14'b10_0???_????_????:    return M_CALL;
            14'b10_1???_????_????:    return M_GOTO;
            14'b11_00??_????_????:    return M_MOVLW;
            14'b11_01??_????_????:    return M_RETLW;
            14'b11_1000_????_????:    return M_IORLW;
            14'b11_1001_????_????:    return M_ANDLW;
            14'b11_1010_????_????:    return M_XORLW;
            14'b11_110?_????_????:    return M_SUBLW;
            14'b11_111?_????_????:    return M_ADDLW;
            default:                  return M_BAD;
        endcase
    endfunction

    function automatic bit byte_alu(input mn_t m);
        return m inside {M_SUBWF, M_DECF, M_IORWF, M_ANDWF, M_XORWF, M_ADDWF, M_MOVF, M_COMF,
                         M_INCF, M_DECFSZ, M_RRF, M_RLF, M_SWAPF, M_INCFSZ};
    endfunction

    function automatic bit lit_alu(input mn_t m);
        return m inside {M_IORLW, M_ANDLW, M_XORLW, M_SUBLW, M_ADDLW};
    endfunction

    function automatic bit reads_f(input mn_t m);
        return byte_alu(m) || (m inside {M_NOP, M_RETURN, M_RETFIE, M_SLEEP, M_CLRWDT, M_MOVWF,
                                         M_CLRF, M_CLRW, M_BCF, M_BSF, M_BTFSC, M_BTFSS});
    endfunction

    function automatic bit writes_f(input mn_t m, input logic d);
        return (m inside {M_MOVWF, M_CLRF, M_BCF, M_BSF}) || (d && byte_alu(m));
    endfunction

    function automatic bit writes_w(input mn_t m, input logic d);
        return (!d && byte_alu(m)) || lit_alu(m) || (m inside {M_CLRW, M_MOVLW, M_RETLW});
    endfunction

    function automatic bit writes_status(input mn_t m);
        return lit_alu(m) || (m inside {M_ADDWF, M_SUBWF, M_ANDWF, M_IORWF, M_XORWF, M_COMF,
                                        M_INCF, M_DECF, M_MOVF, M_CLRF, M_CLRW, M_RLF, M_RRF});
    endfunction

    function automatic exp_t dut_vec();
        return {bus.q_phase, bus.instr_rd_en, bus.incr_pc_en, bus.pc_load_en, bus.pc_load_sel,
                bus.stack_push, bus.stack_pop, bus.regfile_rd_en, bus.alu_en, bus.regfile_wr_en,
                bus.w_wr_en, bus.status_wr_en, bus.nop_cycle, bus.sleeping};
    endfunction

    always @(negedge clk) begin
        exp_t e, a;
        cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = dut_vec();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs clk=%0d got %h expected %h (q,rd,inc,ld,sel,push,pop,rfr,alu,rfw,w,st,nop,slp)",
                         cyc, a, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_clocks(input int n);
        rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            exp_q.push_back('0);
            step();
        end
    endtask

    task automatic run_instr(input logic [13:0] ins, input logic sc, input logic pw,
                             input int rst_phase, input int sleep_clks);
        mn_t  m;
        exp_t e;
        bit   exec, wf, br, sk;
        m    = mnemonic(ins);
        exec = !m_flush;
        wf   = writes_f(m, ins[7]);
        bus.instr_current = ins;
        bus.skip_cond     = sc;
        bus.pcl_wr        = pw;
        for (int p = 0; p < 4; p++) begin
            bus.wake = ($urandom_range(0, 3) == 0);
            e = '0;
            if (p == rst_phase) begin
                rst = 1'b1;
                exp_q.push_back(e);
                step();
                reset_clocks(2);
                rst = 1'b0;
                m_flush = 1'b1;
                m_hold  = 1'b1;
                return;
            end
            e.q   = 2'(p);
            e.nop = m_flush;
            case (p)
                0: e.incr  = !(m_flush && m_hold);
                1: e.rf_rd = exec && reads_f(m);
                2: e.alu   = exec && !(m inside {M_GOTO, M_CALL, M_RETURN, M_RETFIE, M_SLEEP, M_CLRWDT});
                default: begin
                    e.instr_rd = 1'b1;
                    if (exec) begin
                        e.rf_wr   = wf;
                        e.w_wr    = writes_w(m, ins[7]);
                        e.st_wr   = writes_status(m);
                        e.pc_load = m inside {M_GOTO, M_CALL, M_RETURN, M_RETFIE, M_RETLW};
                        e.pc_sel  = m inside {M_RETURN, M_RETFIE, M_RETLW};
                        e.pop     = e.pc_sel;
                        e.push    = (m == M_CALL);
                    end
                end
            endcase
            exp_q.push_back(e);
            step();
        end
        br = exec && (m inside {M_GOTO, M_CALL, M_RETURN, M_RETFIE, M_RETLW});
        sk = exec && (((m inside {M_DECFSZ, M_INCFSZ}) && sc) || (m == M_BTFSC && !sc)
                      || (m == M_BTFSS && sc));
        m_flush = br || (exec && pw && wf) || sk;
        m_hold  = br || (exec && pw && wf);
        if (exec && m == M_SLEEP) begin
            for (int c = 0; c <= sleep_clks; c++) begin
                bus.wake   = (c == sleep_clks);
                e          = '0;
                e.sleeping = 1'b1;
                exp_q.push_back(e);
                step();
            end
            bus.wake = 1'b0;
        end
    endtask

    function automatic logic [13:0] rand_instr();
        logic [13:0] specials [5];
        logic [3:0]  op;
        logic [6:0]  f;
        logic        d;
        specials = '{14'h0000, 14'h0008, 14'h0009, 14'h0063, 14'h0064};
        op = 4'($urandom);
        f  = 7'($urandom);
        d  = 1'($urandom);
        case ($urandom_range(0, 9))
            0:       return specials[$urandom_range(0, 4)];
            1, 2, 3: begin
                if (op == 4'b0000) d = 1'b1;
                return {2'b00, op, d, f};
            end
            4, 5:    return {2'b01, op, d, f};
            6:       return {2'b10, op, d, f};
            default: begin
                if (op == 4'b1011) op = 4'b1000;
                return {2'b11, op, d, f};
            end
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.instr_current = '0;
        bus.skip_cond     = 1'b0;
        bus.pcl_wr        = 1'b0;
        bus.wake          = 1'b0;
        step();
        reset_clocks(3);
        rst = 1'b0;
        m_flush = 1'b1;
        m_hold  = 1'b1;

        run_instr(14'h3005, 1'b0, 1'b0, -1, 0);
        run_instr(14'h3005, 1'b0, 1'b0, -1, 0);
        run_instr(14'h07A0, 1'b0, 1'b0, -1, 0);
        run_instr(14'h2923, 1'b0, 1'b0, -1, 0);
        run_instr(14'h3001, 1'b0, 1'b0, -1, 0);
        run_instr(14'h3002, 1'b0, 1'b0, -1, 0);
        run_instr(14'h1C03, 1'b1, 1'b0, -1, 0);
        run_instr(14'h3003, 1'b0, 1'b0, -1, 0);
        run_instr(14'h1C03, 1'b0, 1'b0, -1, 0);
        run_instr(14'h3004, 1'b0, 1'b0, -1, 0);
        run_instr(14'h2005, 1'b0, 1'b0, -1, 0);
        run_instr(14'h3006, 1'b0, 1'b0, -1, 0);
        run_instr(14'h0008, 1'b0, 1'b0, -1, 0);
        run_instr(14'h3007, 1'b0, 1'b0, -1, 0);
        run_instr(14'h0782, 1'b0, 1'b1, -1, 0);
        run_instr(14'h3008, 1'b0, 1'b0, -1, 0);
        run_instr(14'h0BA0, 1'b1, 1'b0, -1, 0);
        run_instr(14'h3009, 1'b0, 1'b0, -1, 0);
        run_instr(14'h0063, 1'b0, 1'b0, -1, 10);
        run_instr(14'h300A, 1'b0, 1'b0, -1, 0);
        run_instr(14'h07A0, 1'b0, 1'b0, 2, 0);
        run_instr(14'h300B, 1'b0, 1'b0, -1, 0);
        run_instr(14'h300C, 1'b0, 1'b0, -1, 0);

        for (int n = 0; n < 300; n++) begin
            run_instr(rand_instr(), 1'($urandom), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 3)) : -1,
                      int'($urandom_range(1, 12)));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
